// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite arbiter and its sub-blocks.
// Latency: none, declarations only.
// Backpressure: not applicable.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first active request at or after rr_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the grant.
module rr_arbiter #(
  parameter int num_requesters = 2
) (
  input  logic [num_requesters-1:0]         req,
  input  logic [$clog2(num_requesters)-1:0] rr_ptr,
  output logic                              grant_valid,
  output logic [$clog2(num_requesters)-1:0] grant_idx
);

  localparam int idx_w = $clog2(num_requesters);

  int               cand;
  logic [idx_w-1:0] cand_idx;

  // Scan requesters in priority order starting at rr_ptr; first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < num_requesters; k++) begin
      cand     = (int'(rr_ptr) + k) % num_requesters;
      cand_idx = idx_w'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite slave between num_masters masters, one whole transaction per grant.
// Latency: request seen in IDLE drives m-side valid the next cycle; 3-cycle minimum per transaction.
// Backpressure: ungranted masters see no ready and keep their valids pending; slave stalls pass straight through.
module axi4_lite_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int addr_width  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream (master-facing) ports
  input  logic [addr_width-1:0] s_axi_awaddr  [num_masters],
  input  logic [2:0]            s_axi_awprot  [num_masters],
  input  logic                  s_axi_awvalid [num_masters],
  output logic                  s_axi_awready [num_masters],
  input  logic [31:0]           s_axi_wdata   [num_masters],
  input  logic [3:0]            s_axi_wstrb   [num_masters],
  input  logic                  s_axi_wvalid  [num_masters],
  output logic                  s_axi_wready  [num_masters],
  output logic [1:0]            s_axi_bresp   [num_masters],
  output logic                  s_axi_bvalid  [num_masters],
  input  logic                  s_axi_bready  [num_masters],
  input  logic [addr_width-1:0] s_axi_araddr  [num_masters],
  input  logic [2:0]            s_axi_arprot  [num_masters],
  input  logic                  s_axi_arvalid [num_masters],
  output logic                  s_axi_arready [num_masters],
  output logic [31:0]           s_axi_rdata   [num_masters],
  output logic [1:0]            s_axi_rresp   [num_masters],
  output logic                  s_axi_rvalid  [num_masters],
  input  logic                  s_axi_rready  [num_masters],
  // downstream (slave-facing) port
  output logic [addr_width-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [addr_width-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int idx_w = $clog2(num_masters);

  arb_state_t             state, state_nxt;
  logic [idx_w-1:0]       grant_idx, grant_nxt;
  logic [idx_w-1:0]       rr_ptr, rr_ptr_nxt;
  logic [idx_w-1:0]       ptr_after;
  logic                   aw_done, aw_done_nxt;
  logic                   w_done, w_done_nxt;
  logic [num_masters-1:0] req;
  logic                   arb_vld;
  logic [idx_w-1:0]       arb_idx;
  logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // A master requests when it offers either an address write or an address read.
  always_comb begin
    req = '0;
    for (int i = 0; i < num_masters; i++) begin
      req[i] = s_axi_awvalid[i] | s_axi_arvalid[i];
    end
  end

  rr_arbiter #(
    .num_requesters (num_masters)
  ) u_rr_arbiter (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_valid (arb_vld),
    .grant_idx   (arb_idx)
  );

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign b_hs  = m_axi_bvalid  & m_axi_bready;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid  & m_axi_rready;

  // Priority moves to the master just after the one that finished.
  assign ptr_after = (int'(grant_idx) == num_masters - 1) ? '0 : grant_idx + idx_w'(1);

  // State, grant and completion-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      aw_done   <= aw_done_nxt;
      w_done    <= w_done_nxt;
    end
  end

  // Transaction sequencing: grant in IDLE, then walk request and response phases.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_idx;
    rr_ptr_nxt  = rr_ptr;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        if (arb_vld) begin
          grant_nxt = arb_idx;
          // a master offering both gets its write first
          state_nxt = s_axi_awvalid[arb_idx] ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_nxt   = IDLE;
          rr_ptr_nxt  = ptr_after;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      RD_REQ: begin
        if (ar_hs) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_after;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream port: payload always follows grant_idx, handshakes only in their phase.
  always_comb begin
    m_axi_awaddr  = s_axi_awaddr[grant_idx];
    m_axi_awprot  = s_axi_awprot[grant_idx];
    m_axi_wdata   = s_axi_wdata[grant_idx];
    m_axi_wstrb   = s_axi_wstrb[grant_idx];
    m_axi_araddr  = s_axi_araddr[grant_idx];
    m_axi_arprot  = s_axi_arprot[grant_idx];
    // done flags stop a second AW or W beat while waiting for the other channel
    m_axi_awvalid = (state == WR_REQ) && !aw_done && s_axi_awvalid[grant_idx];
    m_axi_wvalid  = (state == WR_REQ) && !w_done  && s_axi_wvalid[grant_idx];
    m_axi_bready  = (state == WR_RESP) && s_axi_bready[grant_idx];
    m_axi_arvalid = (state == RD_REQ)  && s_axi_arvalid[grant_idx];
    m_axi_rready  = (state == RD_RESP) && s_axi_rready[grant_idx];
  end

  // Upstream ports: only the granted master sees ready/valid; everyone else reads zero.
  always_comb begin
    logic sel;
    logic bv;
    logic rv;
    sel = 1'b0;
    bv  = 1'b0;
    rv  = 1'b0;
    for (int i = 0; i < num_masters; i++) begin
      sel = (grant_idx == idx_w'(i));
      bv  = sel && (state == WR_RESP) && m_axi_bvalid;
      rv  = sel && (state == RD_RESP) && m_axi_rvalid;
      s_axi_awready[i] = sel && (state == WR_REQ) && !aw_done && m_axi_awready;
      s_axi_wready[i]  = sel && (state == WR_REQ) && !w_done  && m_axi_wready;
      s_axi_bvalid[i]  = bv;
      s_axi_bresp[i]   = bv ? m_axi_bresp : AXI_RESP_OKAY;
      s_axi_arready[i] = sel && (state == RD_REQ) && m_axi_arready;
      s_axi_rvalid[i]  = rv;
      s_axi_rdata[i]   = rv ? m_axi_rdata : 32'h0;
      s_axi_rresp[i]   = rv ? m_axi_rresp : AXI_RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter with two masters and a zero-wait register slave model.
// Latency: slave answers B/R in the cycle after the request handshake.
// Backpressure: slave is always ready; stalls come from master-side bready/rready.
module tb_axi4_lite_arbiter;
  import axi4_lite_pkg::*;

  localparam int NM = 2;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] s_axi_awaddr  [NM];
  logic [2:0]    s_axi_awprot  [NM];
  logic          s_axi_awvalid [NM];
  logic          s_axi_awready [NM];
  logic [31:0]   s_axi_wdata   [NM];
  logic [3:0]    s_axi_wstrb   [NM];
  logic          s_axi_wvalid  [NM];
  logic          s_axi_wready  [NM];
  logic [1:0]    s_axi_bresp   [NM];
  logic          s_axi_bvalid  [NM];
  logic          s_axi_bready  [NM];
  logic [AW-1:0] s_axi_araddr  [NM];
  logic [2:0]    s_axi_arprot  [NM];
  logic          s_axi_arvalid [NM];
  logic          s_axi_arready [NM];
  logic [31:0]   s_axi_rdata   [NM];
  logic [1:0]    s_axi_rresp   [NM];
  logic          s_axi_rvalid  [NM];
  logic          s_axi_rready  [NM];

  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  axi4_lite_arbiter #(.num_masters(NM), .addr_width(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // ---------------- slave model ----------------
  // Stores every write; reads of never-written words return C0DE + address.
  // Address bit 6 or a misaligned address answers SLVERR.
  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;

  logic [31:0]   mem [32];
  logic [31:0]   mem_vld;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [31:0]   w_d;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          t_aw_hs, t_w_hs, t_ar_hs;
  int            aw_cnt = 0;

  assign t_aw_hs = m_axi_awvalid & m_axi_awready;
  assign t_w_hs  = m_axi_wvalid & m_axi_wready;
  assign t_ar_hs = m_axi_arvalid & m_axi_arready;
  assign wa = t_aw_hs ? m_axi_awaddr : aw_a;
  assign wd = t_w_hs ? (m_axi_wdata & {{8{m_axi_wstrb[3]}}, {8{m_axi_wstrb[2]}},
                                       {8{m_axi_wstrb[1]}}, {8{m_axi_wstrb[0]}}}) : w_d;

  always @(posedge clk) begin
    if (rst) begin
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      aw_a         <= '0;
      w_d          <= '0;
      mem_vld      <= '0;
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rresp  <= 2'b00;
      m_axi_rdata  <= '0;
    end else begin
      if (t_aw_hs) begin
        aw_got <= 1'b1;
        aw_a   <= m_axi_awaddr;
        aw_cnt <= aw_cnt + 1;
      end
      if (t_w_hs) begin
        w_got <= 1'b1;
        w_d   <= wd;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if ((t_aw_hs || aw_got) && (t_w_hs || w_got)) begin
        mem[wa[6:2]]     <= wd;
        mem_vld[wa[6:2]] <= 1'b1;
        m_axi_bvalid     <= 1'b1;
        m_axi_bresp      <= (wa[6] || wa[1:0] != 2'b00) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        aw_got           <= 1'b0;
        w_got            <= 1'b0;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (t_ar_hs) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem_vld[m_axi_araddr[6:2]] ? mem[m_axi_araddr[6:2]]
                                                   : {16'hC0DE, 9'h0, m_axi_araddr};
        m_axi_rresp  <= (m_axi_araddr[6] || m_axi_araddr[1:0] != 2'b00) ? AXI_RESP_SLVERR
                                                                         : AXI_RESP_OKAY;
      end
    end
  end

  // ---------------- observers ----------------
  logic any_rv;
  always_comb begin
    any_rv = m_axi_awvalid | m_axi_wvalid | m_axi_bready | m_axi_arvalid | m_axi_rready;
    for (int i = 0; i < NM; i++) begin
      any_rv = any_rv | s_axi_awready[i] | s_axi_wready[i] | s_axi_bvalid[i] |
               s_axi_arready[i] | s_axi_rvalid[i];
    end
  end

  // Sticky flag: any activity on master 1's outputs while monitoring is enabled.
  logic mon_en = 1'b0;
  logic m1_bad;
  always @(negedge clk) begin
    if (!mon_en) m1_bad <= 1'b0;
    else if (s_axi_awready[1] || s_axi_wready[1] || s_axi_bvalid[1] || s_axi_bresp[1] != 2'b00 ||
             s_axi_arready[1] || s_axi_rvalid[1] || s_axi_rdata[1] != 32'h0 ||
             s_axi_rresp[1] != 2'b00)
      m1_bad <= 1'b1;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;
  int aw_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < NM; i++) begin
      s_axi_awaddr[i] = '0; s_axi_awprot[i] = '0; s_axi_awvalid[i] = 1'b0;
      s_axi_wdata[i]  = '0; s_axi_wstrb[i]  = 4'hF; s_axi_wvalid[i] = 1'b0;
      s_axi_bready[i] = 1'b0;
      s_axi_araddr[i] = '0; s_axi_arprot[i] = '0; s_axi_arvalid[i] = 1'b0;
      s_axi_rready[i] = 1'b0;
    end
    cyc();
    cyc();

    // reset state
    chk("rst_state", dut.state, IDLE);
    chk("rst_ptr", dut.rr_ptr, 0);
    chk("rst_grant", dut.grant_idx, 0);
    chk("rst_done", {dut.aw_done, dut.w_done}, 0);
    chk("rst_rv", any_rv, 0);
    rst = 1'b0;

    // single write from master 0: DEADBEEF to 0x04
    mon_en = 1'b1;
    aw_base = aw_cnt;
    s_axi_awaddr[0] = 7'h04; s_axi_awprot[0] = 3'b010; s_axi_awvalid[0] = 1'b1;
    s_axi_wdata[0] = 32'hDEADBEEF; s_axi_wvalid[0] = 1'b1; s_axi_bready[0] = 1'b1;
    #1;
    chk("t1_idle_awvalid", m_axi_awvalid, 0);
    cyc();
    chk("t1_state_wrreq", dut.state, WR_REQ);
    chk("t1_m_awvalid", m_axi_awvalid, 1);
    chk("t1_m_awaddr", m_axi_awaddr, 7'h04);
    chk("t1_m_awprot", m_axi_awprot, 3'b010);
    chk("t1_m_wvalid", m_axi_wvalid, 1);
    chk("t1_m_wdata", m_axi_wdata, 32'hDEADBEEF);
    chk("t1_m_wstrb", m_axi_wstrb, 4'hF);
    chk("t1_s0_awready", s_axi_awready[0], 1);
    chk("t1_s0_wready", s_axi_wready[0], 1);
    cyc();
    chk("t1_state_wrresp", dut.state, WR_RESP);
    chk("t1_s0_bvalid", s_axi_bvalid[0], 1);
    chk("t1_s0_bresp", s_axi_bresp[0], AXI_RESP_OKAY);
    chk("t1_aw_count", 32'(aw_cnt - aw_base), 1);
    chk("t1_m_awvalid_off", m_axi_awvalid, 0);
    s_axi_awvalid[0] = 1'b0; s_axi_wvalid[0] = 1'b0;
    cyc();
    chk("t1_state_idle", dut.state, IDLE);
    chk("t1_s0_bvalid_off", s_axi_bvalid[0], 0);
    chk("t1_rr_ptr", dut.rr_ptr, 1);
    chk("t1_m1_quiet", m1_bad, 0);
    mon_en = 1'b0;

    // simultaneous reads after reset: master 0 then master 1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t2_rst_ptr", dut.rr_ptr, 0);
    s_axi_araddr[0] = 7'h04; s_axi_arprot[0] = 3'b001; s_axi_arvalid[0] = 1'b1; s_axi_rready[0] = 1'b1;
    s_axi_araddr[1] = 7'h08; s_axi_arvalid[1] = 1'b1; s_axi_rready[1] = 1'b1;
    cyc();
    chk("t2_state_rdreq0", dut.state, RD_REQ);
    chk("t2_grant0", dut.grant_idx, 0);
    chk("t2_m_araddr0", m_axi_araddr, 7'h04);
    chk("t2_m_arprot0", m_axi_arprot, 3'b001);
    chk("t2_s0_arready", s_axi_arready[0], 1);
    chk("t2_s1_arready", s_axi_arready[1], 0);
    cyc();
    chk("t2_s0_rvalid", s_axi_rvalid[0], 1);
    chk("t2_s0_rdata", s_axi_rdata[0], 32'hC0DE0004);
    chk("t2_s0_rresp", s_axi_rresp[0], AXI_RESP_OKAY);
    chk("t2_s1_rvalid_off", s_axi_rvalid[1], 0);
    s_axi_arvalid[0] = 1'b0;
    cyc();
    chk("t2_state_idle", dut.state, IDLE);
    chk("t2_rr_ptr_mid", dut.rr_ptr, 1);
    cyc();
    chk("t2_grant1", dut.grant_idx, 1);
    chk("t2_m_araddr1", m_axi_araddr, 7'h08);
    cyc();
    chk("t2_s1_rvalid", s_axi_rvalid[1], 1);
    chk("t2_s1_rdata", s_axi_rdata[1], 32'hC0DE0008);
    chk("t2_s0_rvalid_off", s_axi_rvalid[0], 0);
    s_axi_arvalid[1] = 1'b0;
    cyc();
    chk("t2_rr_ptr_end", dut.rr_ptr, 0);

    // master 1 write with W arriving three cycles after AW
    aw_base = aw_cnt;
    s_axi_awaddr[1] = 7'h10; s_axi_awvalid[1] = 1'b1; s_axi_bready[1] = 1'b1; s_axi_wstrb[1] = 4'hF;
    cyc();
    chk("t3_state_wrreq", dut.state, WR_REQ);
    chk("t3_grant1", dut.grant_idx, 1);
    chk("t3_m_awvalid", m_axi_awvalid, 1);
    chk("t3_m_wvalid_off", m_axi_wvalid, 0);
    cyc();
    chk("t3_aw_done", dut.aw_done, 1);
    chk("t3_hold_wrreq", dut.state, WR_REQ);
    chk("t3_no_dup_aw", m_axi_awvalid, 0);
    s_axi_awvalid[1] = 1'b0;
    cyc();
    chk("t3_still_wrreq", dut.state, WR_REQ);
    chk("t3_aw_count", 32'(aw_cnt - aw_base), 1);
    chk("t3_s1_awready_off", s_axi_awready[1], 0);
    s_axi_wdata[1] = 32'h12345678; s_axi_wvalid[1] = 1'b1;
    #1;
    chk("t3_m_wvalid", m_axi_wvalid, 1);
    chk("t3_m_wdata", m_axi_wdata, 32'h12345678);
    cyc();
    chk("t3_state_wrresp", dut.state, WR_RESP);
    chk("t3_aw_count_end", 32'(aw_cnt - aw_base), 1);
    chk("t3_s1_bvalid", s_axi_bvalid[1], 1);
    chk("t3_s1_bresp", s_axi_bresp[1], AXI_RESP_OKAY);
    s_axi_wvalid[1] = 1'b0;
    cyc();
    chk("t3_state_idle", dut.state, IDLE);
    chk("t3_rr_ptr", dut.rr_ptr, 0);
    chk("t3_aw_done_clr", dut.aw_done, 0);

    // master 0 offers write and read together: write first
    s_axi_awaddr[0] = 7'h44; s_axi_awvalid[0] = 1'b1;
    s_axi_wdata[0] = 32'hCAFEF00D; s_axi_wvalid[0] = 1'b1; s_axi_bready[0] = 1'b1;
    s_axi_araddr[0] = 7'h10; s_axi_arvalid[0] = 1'b1; s_axi_rready[0] = 1'b1;
    cyc();
    chk("t4_state_wrreq", dut.state, WR_REQ);
    chk("t4_grant0", dut.grant_idx, 0);
    cyc();
    chk("t4_state_wrresp", dut.state, WR_RESP);
    chk("t4_s0_bvalid", s_axi_bvalid[0], 1);
    chk("t4_s0_bresp_err", s_axi_bresp[0], AXI_RESP_SLVERR);
    s_axi_awvalid[0] = 1'b0; s_axi_wvalid[0] = 1'b0;
    cyc();
    chk("t4_state_idle", dut.state, IDLE);
    chk("t4_rr_ptr", dut.rr_ptr, 1);
    cyc();
    chk("t4_state_rdreq", dut.state, RD_REQ);
    chk("t4_m_araddr", m_axi_araddr, 7'h10);
    cyc();
    chk("t4_s0_rvalid", s_axi_rvalid[0], 1);
    chk("t4_s0_rdata", s_axi_rdata[0], 32'h12345678);
    chk("t4_s0_rresp", s_axi_rresp[0], AXI_RESP_OKAY);
    s_axi_arvalid[0] = 1'b0;
    cyc();
    chk("t4_rr_ptr_end", dut.rr_ptr, 1);

    // bready stall on master 0 while master 1 waits with a read
    s_axi_awaddr[0] = 7'h08; s_axi_awvalid[0] = 1'b1;
    s_axi_wdata[0] = 32'h0BADF00D; s_axi_wvalid[0] = 1'b1; s_axi_bready[0] = 1'b0;
    cyc();
    chk("t5_grant0", dut.grant_idx, 0);
    s_axi_araddr[1] = 7'h44; s_axi_arvalid[1] = 1'b1; s_axi_rready[1] = 1'b1;
    cyc();
    s_axi_awvalid[0] = 1'b0; s_axi_wvalid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_wrresp", dut.state, WR_RESP);
      chk("t5_bvalid_stable", s_axi_bvalid[0], 1);
      chk("t5_m_bready_low", m_axi_bready, 0);
      chk("t5_no_rd_grant", {m_axi_arvalid, s_axi_arready[1]}, 0);
      cyc();
    end
    s_axi_bready[0] = 1'b1;
    #1;
    chk("t5_m_bready", m_axi_bready, 1);
    cyc();
    chk("t5_state_idle", dut.state, IDLE);
    chk("t5_rr_ptr", dut.rr_ptr, 1);
    cyc();
    chk("t5_grant1", dut.grant_idx, 1);
    cyc();
    chk("t5_s1_rvalid", s_axi_rvalid[1], 1);
    chk("t5_s1_rdata", s_axi_rdata[1], 32'hCAFEF00D);
    chk("t5_s1_rresp_err", s_axi_rresp[1], AXI_RESP_SLVERR);
    s_axi_arvalid[1] = 1'b0;
    cyc();
    chk("t5_rr_ptr_end", dut.rr_ptr, 0);

    // reset in the middle of RD_RESP, then a fresh grant
    s_axi_araddr[0] = 7'h08; s_axi_arvalid[0] = 1'b1; s_axi_rready[0] = 1'b0;
    cyc();
    cyc();
    chk("t6_state_rdresp", dut.state, RD_RESP);
    chk("t6_s0_rvalid", s_axi_rvalid[0], 1);
    chk("t6_s0_rdata", s_axi_rdata[0], 32'h0BADF00D);
    s_axi_arvalid[0] = 1'b0;
    rst = 1'b1;
    cyc();
    chk("t6_rst_state", dut.state, IDLE);
    chk("t6_rst_ptr", dut.rr_ptr, 0);
    chk("t6_rst_grant", dut.grant_idx, 0);
    chk("t6_rst_rv", any_rv, 0);
    rst = 1'b0;
    s_axi_rready[0] = 1'b1;
    s_axi_araddr[1] = 7'h04; s_axi_arvalid[1] = 1'b1; s_axi_rready[1] = 1'b1;
    cyc();
    chk("t6_state_rdreq", dut.state, RD_REQ);
    chk("t6_grant1", dut.grant_idx, 1);
    cyc();
    chk("t6_s1_rvalid", s_axi_rvalid[1], 1);
    chk("t6_s1_rdata", s_axi_rdata[1], 32'hC0DE0004);
    s_axi_arvalid[1] = 1'b0;
    cyc();
    chk("t6_state_idle", dut.state, IDLE);
    chk("t6_rr_ptr_end", dut.rr_ptr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
